// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory write side: bus widths,
// the reset PC the fetcher starts from, and the loader state encodings.
package instr_mem_loader_pkg;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   localparam int INSTR_W      = 32;
   localparam int INSTR_ADDR_W = 32;

   localparam logic [INSTR_ADDR_W-1:0] RESET_PC = 32'h3000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } load_state_e;

endpackage

// File: rtl/instr_mem_loader_packer.sv
// Little-endian byte-to-word assembler: byte k of each group of four lands
// in bits [8k+7:8k]; word_valid flags the byte that completes a word.
module instr_byte_packer
   import instr_mem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               take,
   input  logic [7:0]         byte_data,
   output logic [INSTR_W-1:0] word_next,
   output logic               word_valid
);

   logic [1:0]         cnt_q, cnt_d;
   logic [INSTR_W-1:0] word_q, word_d;

   always_comb begin
      word_next = word_q;
      case (cnt_q)
         2'd0:    word_next[7:0]   = byte_data;
         2'd1:    word_next[15:8]  = byte_data;
         2'd2:    word_next[23:16] = byte_data;
         default: word_next[31:24] = byte_data;
      endcase
      word_valid = take && (cnt_q == 2'd3);

      cnt_d  = cnt_q;
      word_d = word_q;
      if (clr) begin
         cnt_d  = 2'd0;
         word_d = '0;
      end else if (take) begin
         cnt_d  = cnt_q + 2'd1;
         word_d = word_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= 2'd0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams bytes into instruction memory as 32-bit words starting at the reset
// PC, and keeps the CPU fetcher held in reset until a complete load lands.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter logic [INSTR_ADDR_W-1:0] BASE_ADDR     = RESET_PC,
   parameter int                      MEM_WORDS     = 131072,
   parameter int                      LEN_W         = 18,
   parameter bit                      HOLD_AT_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_start,
   input  logic [LEN_W-1:0]        load_len,
   input  logic                    load_abort,
   input  logic                    byte_valid,
   input  logic [7:0]              byte_data,
   output logic                    byte_ready,
   output logic                    we,
   output logic [INSTR_ADDR_W-1:0] waddr,
   output logic [INSTR_W-1:0]      wdata,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [INSTR_W-1:0]      checksum,
   output logic                    cpu_hold
);

   localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MEM_WORDS);

   load_state_e             state_q, state_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [LEN_W-1:0]        word_cnt_q, word_cnt_d;
   logic                    byte_ready_q, byte_ready_d;
   logic                    we_q, we_d;
   logic [INSTR_ADDR_W-1:0] waddr_q, waddr_d;
   logic [INSTR_W-1:0]      wdata_q, wdata_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [INSTR_W-1:0]      checksum_q, checksum_d;
   logic                    cpu_hold_q, cpu_hold_d;

   logic                    take;
   logic                    pack_clr;
   logic [INSTR_W-1:0]      word_next;
   logic                    word_valid;

   // Abort wins over a simultaneous byte handshake, so that byte is dropped.
   assign take     = byte_valid && byte_ready_q && (state_q == ST_RECV) && !load_abort;
   assign pack_clr = ((state_q == ST_IDLE || state_q == ST_DONE) && load_start)
                     || ((state_q == ST_RECV || state_q == ST_WRITE) && load_abort);

   instr_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (pack_clr),
      .take       (take),
      .byte_data  (byte_data),
      .word_next  (word_next),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      byte_ready_d = byte_ready_q;
      we_d         = OFF;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;
      checksum_d   = checksum_q;
      cpu_hold_d   = cpu_hold_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_start) begin
               len_d      = load_len;
               word_cnt_d = '0;
               waddr_d    = BASE_ADDR;
               done_d     = OFF;
               err_d      = OFF;
               checksum_d = '0;
               cpu_hold_d = ON;
               busy_d     = ON;
               if (load_len == '0) begin
                  // An empty program is a complete one: release the CPU.
                  state_d    = ST_DONE;
                  done_d     = ON;
                  busy_d     = OFF;
                  cpu_hold_d = OFF;
               end else if ({1'b0, load_len} > MAX_LEN) begin
                  state_d = ST_DONE;
                  err_d   = ON;
                  busy_d  = OFF;
               end else begin
                  state_d      = ST_RECV;
                  byte_ready_d = ON;
               end
            end
         end

         ST_RECV: begin
            if (load_abort) begin
               state_d      = ST_DONE;
               byte_ready_d = OFF;
               err_d        = ON;
               busy_d       = OFF;
            end else if (word_valid) begin
               state_d      = ST_WRITE;
               byte_ready_d = OFF;
               we_d         = ON;
               wdata_d      = word_next;
            end
         end

         ST_WRITE: begin
            // The write on the bus this cycle lands regardless of an abort.
            checksum_d = checksum_q + wdata_q;
            if (load_abort) begin
               state_d = ST_DONE;
               err_d   = ON;
               busy_d  = OFF;
            end else begin
               waddr_d    = waddr_q + 32'd4;
               word_cnt_d = word_cnt_q + LEN_W'(1);
               if ((word_cnt_q + LEN_W'(1)) == len_q) begin
                  state_d    = ST_DONE;
                  done_d     = ON;
                  busy_d     = OFF;
                  cpu_hold_d = OFF;
               end else begin
                  state_d      = ST_RECV;
                  byte_ready_d = ON;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         word_cnt_q   <= '0;
         byte_ready_q <= OFF;
         we_q         <= OFF;
         waddr_q      <= BASE_ADDR;
         wdata_q      <= '0;
         busy_q       <= OFF;
         done_q       <= OFF;
         err_q        <= OFF;
         checksum_q   <= '0;
         cpu_hold_q   <= HOLD_AT_RESET;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_ready_q <= byte_ready_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         checksum_q   <= checksum_d;
         cpu_hold_q   <= cpu_hold_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign we         = we_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign checksum   = checksum_q;
   assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a word-level write scoreboard built
// from the byte stream, plus hand-computed expectations for each scenario.
module tb_instr_mem_loader;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [17:0] load_len;
   logic        load_abort;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] checksum;
   logic        cpu_hold;

   instr_mem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_len   (load_len),
      .load_abort (load_abort),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .checksum   (checksum),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          wr_count = 0;
   int          wc0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] model_sum;
   logic [7:0]  stim[$];
   time         t_acc;
   time         t_first;
   time         t_done;
   bit          ok;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Expected writes: word i is bytes 4i..4i+3 little-endian at BASE + 4i.
   task automatic expect_words(input int n);
      logic [31:0] w;
      model_sum = 32'd0;
      for (int i = 0; i < n; i++) begin
         w = 32'(stim[4*i]) + 32'(stim[4*i+1]) * 32'd256
           + 32'(stim[4*i+2]) * 32'd65536 + 32'(stim[4*i+3]) * 32'd16777216;
         exp_addr_q.push_back(BASE + 32'(4 * i));
         exp_data_q.push_back(w);
         model_sum = model_sum + w;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && we) begin
         wr_count++;
         total++;
         if (exp_addr_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: addr %h data %h", waddr, wdata);
         end else begin
            logic [31:0] ea, ed;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (waddr !== ea || wdata !== ed) begin
               bad++;
               $display("FAIL write: got %h@%h expected %h@%h", wdata, waddr, ed, ea);
            end
         end
         if (byte_ready) begin
            bad++;
            $display("FAIL ready_during_write: byte_ready=1 with we=1");
         end
      end
   end

   task automatic start(input int len);
      @(posedge clk); #1;
      load_len   = 18'(len);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      acc        = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         if (byte_ready) begin
            @(posedge clk);
            t_acc = $time;
            #1;
            acc = 1'b1;
         end
      end
      byte_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL byte_timeout: byte %h not accepted", b);
      end
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_range(input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) begin
         send_byte(stim[i], gap);
         if (i == first) t_first = t_acc;
      end
   endtask

   task automatic wait_end(output bit got);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge clk);
         t_done = $time;
         #1;
         if (done || err) got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL end_timeout: neither done nor err");
      end
   endtask

   task automatic set_prog2();
      stim = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; load_len = '0; load_abort = 1'b0;
      byte_valid = 1'b0; byte_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chkb("rst_byte_ready", byte_ready, 1'b0);
      chkb("rst_we", we, 1'b0);
      chk("rst_waddr", waddr, BASE);
      chk("rst_wdata", wdata, 32'h0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_done", done, 1'b0);
      chkb("rst_err", err, 1'b0);
      chk("rst_checksum", checksum, 32'h0);
      chkb("rst_cpu_hold", cpu_hold, 1'b1);

      // Two-word load, back-to-back bytes
      set_prog2();
      expect_words(2);
      chk("model_word1", exp_data_q[1], 32'h0010_0093);
      wc0 = wr_count;
      start(2);
      chkb("start_busy", busy, 1'b1);
      send_range(0, 7, 0);
      wait_end(ok);
      chk("b2b_cycles", 32'((t_done - t_first) / 10 + 1), 32'd10);
      chkb("b2b_done", done, 1'b1);
      chkb("b2b_err", err, 1'b0);
      chkb("b2b_cpu_hold", cpu_hold, 1'b0);
      chkb("b2b_busy", busy, 1'b0);
      chk("b2b_checksum", checksum, 32'h0010_00A6);
      chk("b2b_writes", 32'(wr_count - wc0), 32'd2);
      chk("b2b_waddr", waddr, 32'h3000_0008);
      chk("b2b_pending", 32'(exp_addr_q.size()), 32'd0);

      // Same load with byte_valid toggling every other cycle
      expect_words(2);
      wc0 = wr_count;
      start(2);
      send_range(0, 7, 1);
      wait_end(ok);
      chkb("stall_done", done, 1'b1);
      chk("stall_checksum", checksum, model_sum);
      chk("stall_writes", 32'(wr_count - wc0), 32'd2);
      chk("stall_pending", 32'(exp_addr_q.size()), 32'd0);

      // Zero length completes immediately without writing
      wc0 = wr_count;
      start(0);
      chkb("len0_done", done, 1'b1);
      chkb("len0_err", err, 1'b0);
      chkb("len0_busy", busy, 1'b0);
      chk("len0_checksum", checksum, 32'h0);
      repeat (3) @(posedge clk);
      #1 chk("len0_writes", 32'(wr_count - wc0), 32'd0);

      // Length beyond memory depth is rejected
      wc0 = wr_count;
      start(131073);
      chkb("big_err", err, 1'b1);
      chkb("big_done", done, 1'b0);
      chkb("big_cpu_hold", cpu_hold, 1'b1);
      chkb("big_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1 chk("big_writes", 32'(wr_count - wc0), 32'd0);

      // Abort after 6 bytes of a 3-word load: only word 0 is written
      stim = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C};
      expect_words(1);
      wc0 = wr_count;
      start(3);
      send_range(0, 5, 0);
      load_abort = 1'b1;
      @(posedge clk); #1;
      load_abort = 1'b0;
      chkb("abort_err", err, 1'b1);
      chkb("abort_done", done, 1'b0);
      chkb("abort_cpu_hold", cpu_hold, 1'b1);
      chkb("abort_busy", busy, 1'b0);
      chkb("abort_ready", byte_ready, 1'b0);
      chk("abort_checksum", checksum, 32'h0403_0201);
      repeat (3) @(posedge clk);
      #1 chk("abort_writes", 32'(wr_count - wc0), 32'd1);

      // Following one-word load starts over at the base address
      stim = {8'h37, 8'h05, 8'h00, 8'h30};
      expect_words(1);
      wc0 = wr_count;
      start(1);
      chkb("reload_err_cleared", err, 1'b0);
      send_range(0, 3, 0);
      wait_end(ok);
      chkb("reload_done", done, 1'b1);
      chkb("reload_err", err, 1'b0);
      chkb("reload_cpu_hold", cpu_hold, 1'b0);
      chk("reload_checksum", checksum, 32'h3000_0537);
      chk("reload_waddr", waddr, 32'h3000_0004);
      chk("reload_writes", 32'(wr_count - wc0), 32'd1);

      // load_start while busy is ignored
      set_prog2();
      expect_words(2);
      wc0 = wr_count;
      start(2);
      send_range(0, 1, 0);
      start(5);
      chkb("busy_start_busy", busy, 1'b1);
      send_range(2, 7, 0);
      wait_end(ok);
      chkb("busy_start_done", done, 1'b1);
      chk("busy_start_checksum", checksum, 32'h0010_00A6);
      chk("busy_start_writes", 32'(wr_count - wc0), 32'd2);
      chk("busy_start_waddr", waddr, 32'h3000_0008);

      // Asynchronous reset between edges while a write is on the bus
      set_prog2();
      expect_words(2);
      start(2);
      send_range(0, 3, 0);
      chkb("pre_rst_we", we, 1'b1);
      #2 rst = 1'b1;
      #1;
      chkb("arst_we", we, 1'b0);
      chkb("arst_busy", busy, 1'b0);
      chkb("arst_ready", byte_ready, 1'b0);
      chk("arst_waddr", waddr, BASE);
      chkb("arst_cpu_hold", cpu_hold, 1'b1);
      chk("arst_checksum", checksum, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      wc0 = wr_count;
      repeat (10) @(posedge clk);
      #1;
      chk("arst_no_writes", 32'(wr_count - wc0), 32'd0);
      chkb("arst_idle_ready", byte_ready, 1'b0);
      chkb("arst_idle_done", done, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
